pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries an opaque payload bus. Compared with the fixed per-field stage registers, it adds backpressure, so a downstream stall no longer requires a global freeze. It also adds registered-ready timing closure and a saturating stall-cycle counter for performance analysis.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_stage_skid_sat_counter.sv | 24 ++
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 tb/tb_pipe_stage_skid.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and default widths.
package pipe_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } stageState_e;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional two-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter bit          SKID  = 1'b1,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       level,
    input  logic             cntClr,
    output logic [CNT_W-1:0] stallCnt
);

    stageState_e      state, stateNxt;
    logic [WIDTH-1:0] mainReg, skidReg;
    logic             accept, take;
    logic             loadMainIn, loadMainSkid, loadSkid, clearRegs;

    // With SKID the ready is decoded from state only, cutting the outReady path.
    assign inReady  = SKID ? (state != ST_FULL) : (!outValid || outReady);
    assign outValid = (state != ST_EMPTY);
    assign outData  = mainReg;
    assign level    = state;
    assign accept   = inValid && inReady;
    assign take     = outValid && outReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt     = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        clearRegs    = 1'b0;
        if (flush) begin
            stateNxt  = ST_EMPTY;
            clearRegs = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        stateNxt   = ST_MAIN;
                        loadMainIn = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (accept && take) begin
                        loadMainIn = 1'b1;
                    end else if (accept && SKID) begin
                        stateNxt = ST_FULL;
                        loadSkid = 1'b1;
                    end else if (take) begin
                        stateNxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        stateNxt     = ST_MAIN;
                        loadMainSkid = 1'b1;
                    end
                end
                default: stateNxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainReg <= '0;
            skidReg <= '0;
        end else if (clearRegs) begin
            mainReg <= '0;
            skidReg <= '0;
        end else begin
            if (loadMainIn) begin
                mainReg <= inData;
            end else if (loadMainSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkid) begin
                skidReg <= inData;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) uStallCnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cntClr),
        .inc  (outValid && !outReady),
        .count(stallCnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: three stage instances share one stimulus; a queue model checks every cycle.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic [31:0] inData = '0;
    logic        outReady = 1'b0;
    logic        cntClr = 1'b0;

    logic        aInReady, aOutValid, bInReady, bOutValid, cInReady, cOutValid;
    logic [31:0] aOutData, bOutData, cOutData;
    logic [1:0]  aLevel, bLevel, cLevel;
    logic [15:0] aStall, bStall;
    logic [1:0]  cStall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(32), .SKID(1'b1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(aInReady),
        .inData(inData), .outValid(aOutValid), .outReady(outReady), .outData(aOutData),
        .level(aLevel), .cntClr(cntClr), .stallCnt(aStall));

    pipe_stage_skid #(.WIDTH(32), .SKID(1'b0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(bInReady),
        .inData(inData), .outValid(bOutValid), .outReady(outReady), .outData(bOutData),
        .level(bLevel), .cntClr(cntClr), .stallCnt(bStall));

    pipe_stage_skid #(.WIDTH(32), .SKID(1'b1), .CNT_W(2)) dutC (
        .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(cInReady),
        .inData(inData), .outValid(cOutValid), .outReady(outReady), .outData(cOutData),
        .level(cLevel), .cntClr(cntClr), .stallCnt(cStall));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of in-flight words, capacity 2 (skid) or 1 (no skid).
    logic [31:0] qS[$];
    logic [31:0] qB[$];
    logic [31:0] orS = '0, orB = '0;
    int          cA = 0, cB = 0, cC = 0;

    always @(negedge clk) begin
        logic rdyS, rdyB, accS, accB, tkS, tkB;
        if (rst) begin
            qS.delete(); qB.delete();
            orS = '0; orB = '0;
            cA = 0; cB = 0; cC = 0;
        end
        rdyS = (qS.size() < 2);
        rdyB = (qB.size() == 0) || outReady;

        check("A.inReady",  {31'd0, aInReady},  {31'd0, rdyS});
        check("A.outValid", {31'd0, aOutValid}, {31'd0, qS.size() != 0});
        check("A.outData",  aOutData, orS);
        check("A.level",    {30'd0, aLevel}, 32'(qS.size()));
        check("A.stallCnt", {16'd0, aStall}, 32'(cA));
        check("B.inReady",  {31'd0, bInReady},  {31'd0, rdyB});
        check("B.outValid", {31'd0, bOutValid}, {31'd0, qB.size() != 0});
        check("B.outData",  bOutData, orB);
        check("B.level",    {30'd0, bLevel}, 32'(qB.size()));
        check("B.stallCnt", {16'd0, bStall}, 32'(cB));
        check("C.outData",  cOutData, orS);
        check("C.stallCnt", {30'd0, cStall}, 32'(cC));

        if (!rst) begin
            accS = inValid && rdyS;
            tkS  = (qS.size() != 0) && outReady;
            accB = inValid && rdyB;
            tkB  = (qB.size() != 0) && outReady;
            if (cntClr) begin
                cA = 0; cC = 0; cB = 0;
            end else begin
                if ((qS.size() != 0) && !outReady) begin
                    if (cA < 65535) cA++;
                    if (cC < 3) cC++;
                end
                if ((qB.size() != 0) && !outReady && cB < 65535) cB++;
            end
            if (flush) begin
                qS.delete(); orS = '0;
                qB.delete(); orB = '0;
            end else begin
                if (tkS) void'(qS.pop_front());
                if (accS) qS.push_back(inData);
                if (qS.size() != 0) orS = qS[0];
                if (tkB) void'(qB.pop_front());
                if (accB) qB.push_back(inData);
                if (qB.size() != 0) orB = qB[0];
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                       input logic f, input logic c);
        inValid = v; inData = d; outReady = r; flush = f; cntClr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of traffic
        cyc(1, 32'h10, 0, 0, 0);
        cyc(1, 32'h11, 0, 0, 0);
        check("pre-reset A.level", {30'd0, aLevel}, 32'd2);
        rst = 1'b1;
        #1;
        check("rst A.outValid", {31'd0, aOutValid}, 32'd0);
        check("rst A.outData",  aOutData, 32'd0);
        check("rst A.level",    {30'd0, aLevel}, 32'd0);
        check("rst A.stallCnt", {16'd0, aStall}, 32'd0);
        check("rst A.inReady",  {31'd0, aInReady}, 32'd1);
        check("rst B.inReady",  {31'd0, bInReady}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        cyc(1, 32'hA5A5_0001, 1, 0, 0);
        check("first A.outValid", {31'd0, aOutValid}, 32'd1);
        check("first A.outData",  aOutData, 32'hA5A5_0001);
        check("first A.level",    {30'd0, aLevel}, 32'd1);
        cyc(0, 32'h0, 1, 0, 0);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 32'(i), 1, 0, 0);
            check("stream A.outData", aOutData, 32'(i));
            check("stream A.inReady", {31'd0, aInReady}, 32'd1);
        end
        cyc(0, 32'h0, 1, 0, 0);
        check("stream A.stallCnt", {16'd0, aStall}, 32'd0);

        // Backpressure from word 2
        cyc(1, 32'd1, 1, 0, 0);
        cyc(1, 32'd2, 1, 0, 0);
        cyc(1, 32'd3, 0, 0, 0);
        check("bp A.level",   {30'd0, aLevel}, 32'd2);
        check("bp A.inReady", {31'd0, aInReady}, 32'd0);
        check("bp A.outData", aOutData, 32'd2);
        cyc(1, 32'd4, 0, 0, 0);
        cyc(1, 32'd4, 0, 0, 0);
        check("bp hold A.outData", aOutData, 32'd2);
        cyc(1, 32'd4, 1, 0, 0);
        check("rel A.outData", aOutData, 32'd3);
        check("rel A.inReady", {31'd0, aInReady}, 32'd1);
        cyc(1, 32'd4, 1, 0, 0);
        check("rel2 A.outData", aOutData, 32'd4);
        cyc(0, 32'h0, 1, 0, 0);
        check("rel A.level",    {30'd0, aLevel}, 32'd0);
        check("rel A.stallCnt", {16'd0, aStall}, 32'd3);

        // Flush while FULL, with a word offered in the same cycle
        cyc(1, 32'h11, 0, 0, 0);
        cyc(1, 32'h22, 0, 0, 0);
        check("pre-flush A.level", {30'd0, aLevel}, 32'd2);
        cyc(1, 32'h77, 0, 1, 0);
        check("flush A.level",    {30'd0, aLevel}, 32'd0);
        check("flush A.outValid", {31'd0, aOutValid}, 32'd0);
        check("flush A.outData",  aOutData, 32'd0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // Combinational ready in the non-skid instance
        cyc(1, 32'h5, 1, 0, 0);
        inValid = 1'b0;
        outReady = 1'b0;
        #1 check("noskid B.inReady low", {31'd0, bInReady}, 32'd0);
        outReady = 1'b1;
        #1 check("noskid B.inReady high", {31'd0, bInReady}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h100 + 32'(i), 1, 0, 0);
            check("noskid B.outData", bOutData, 32'h100 + 32'(i));
        end
        cyc(0, 32'h0, 1, 0, 0);

        // Counter saturation and clear
        cyc(0, 32'h0, 1, 0, 1);
        check("clr A.stallCnt", {16'd0, aStall}, 32'd0);
        cyc(1, 32'h9, 1, 0, 0);
        repeat (6) cyc(0, 32'h0, 0, 0, 0);
        check("sat C.stallCnt", {30'd0, cStall}, 32'd3);
        check("sat A.stallCnt", {16'd0, aStall}, 32'd6);
        cyc(0, 32'h0, 0, 0, 1);
        check("clr C.stallCnt", {30'd0, cStall}, 32'd0);
        check("clr2 A.stallCnt", {16'd0, aStall}, 32'd0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
